ret_addr_stack: RTL and testbench
=================================

# ret_addr_stack

Parametrised return-address stack for the decode stage of the pipelined processor: stores PC+1 on a call and yields the saved address on a return. It generalises the fixed call stack in three ways: configurable depth and address width, a selectable overflow policy, and a single speculative checkpoint/restore so a squashed call or return can be undone. It also provides status outputs: count, full/empty and sticky error flags.

## Interface
- DEPTH, 8: number of entries; must be ≥2 and a power of two.
- AW, 12: address width in bits.
- OVF_WRAP, 0: overflow policy. 1 = overwrite the oldest entry (circular); 0 = drop the push and flag overflow.
- CW, $clog2(DEPTH+1): width of the count output (derived, not overridden).

- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  reset; synchronous and active-high.
- push  in  1  push push_addr this cycle.
- pop  in  1  pop the top entry this cycle.
- push_addr  in  AW  address to push (PC+1).
- ckpt  in  1  snapshot the stack pointer and count.
- restore  in  1  return the stack pointer and count to the snapshot.
- clr_err  in  1  clear the sticky error flags.
- top_addr  out  AW  current top entry; combinational; 0 when empty.
- count  out  CW  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; set by a push while full with OVF_WRAP=0, or an overwrite with OVF_WRAP=1.
- underflow  out  1  sticky; set by a pop while empty.

## Operation
- Storage: DEPTH×AW register array, circular write pointer sp (log2 DEPTH bits), count register.
- top = mem[sp-1 mod DEPTH].
- Command priority, highest first: rst > restore > push/pop. ckpt is independent of the others.
- Push only, not full: mem[sp]←push_addr; sp+1; count+1.
- Push only, full:
  - OVF_WRAP=1: write mem[sp], sp+1 (oldest entry lost), count stays DEPTH, overflow←1.
  - OVF_WRAP=0: no state change, overflow←1.
- Pop only, not empty: sp-1, count-1. Memory is untouched.
- Pop only, empty: no state change, underflow←1.
- Push and pop together, not empty: mem[sp-1]←push_addr (replace top); sp and count unchanged; no flag set, even when full.
- Push and pop together, empty: treated as push only; count→1; no underflow.
- ckpt: saved_sp←sp, saved_cnt←count, using pre-update values even when push/pop or restore occur in the same cycle.
- restore: sp←saved_sp, count←saved_cnt; any push/pop in that cycle is ignored. Entries are not restored, so slots overwritten after the checkpoint keep their new contents.
- clr_err: clears overflow and underflow. A new error in the same cycle wins, so the flag stays 1.
- Pointer arithmetic is modulo DEPTH. The count saturates at 0 and DEPTH as described above.

## Timing
- Reset (synchronous) produces:
  - all memory entries, sp, count, saved_sp and saved_cnt = 0
  - top_addr = 0, count = 0, empty = 1, full = 0
  - overflow = 0, underflow = 0
- rst asserted in the middle of any operation overrides every other input in that cycle.
- Commands are sampled on the rising clk edge. count, empty, full, the flags and the state behind top_addr update one cycle after the command.
- top_addr is combinational from the registered state, so there is no extra latency: after a push at edge N, top_addr equals push_addr after edge N.
- No handshake: every command is accepted every cycle. The caller is responsible for pulse qualification.
- Back-to-back push/pop in consecutive cycles is fully supported with no bubble.

## Test plan
- Reset, then push 0x101, 0x102, 0x103 in consecutive cycles → top_addr=0x103 and count=3. Three pops → top_addr reads 0x102, 0x101, then 0; empty=1; underflow=0.
- DEPTH=8, OVF_WRAP=0: push 0x200..0x208 (9 pushes) → count=8, full=1, overflow=1, top_addr=0x207. Then clr_err → overflow=0.
- DEPTH=8, OVF_WRAP=1: the same 9 pushes → top_addr=0x208, count=8. Then 8 pops → 0x208 down to 0x201 (0x200 lost); empty=1.
- Pop on an empty stack → underflow=1, count=0. Push and pop together on an empty stack with push_addr=0x0AA → count=1, top_addr=0x0AA, underflow unchanged.
- Push 0x010, 0x020; ckpt; push 0x030; pop; pop; restore → count=2, sp restored. Simultaneous push 0x040 + pop → top_addr=0x040 and count unchanged.
- Push 0x111 with rst asserted in the same cycle → count=0, top_addr=0, flags=0. Restore issued after the reset → count=0.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Return-address stack: circular storage, configurable overflow policy,
// one speculative checkpoint of pointer/count, and sticky error flags.
module ret_addr_stack #(
  parameter int DEPTH    = 8,
  parameter int AW       = 12,
  parameter int OVF_WRAP = 0,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic          ckpt,
  input  logic          restore,
  input  logic          clr_err,
  output logic [AW-1:0] top_addr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp, sp_nxt, sp_m1, sp_p1, saved_sp, wr_idx;
  logic [CW-1:0] cnt, cnt_nxt, saved_cnt;
  logic          wr_en, ovf_set, unf_set;

  assign sp_m1     = sp - PW'(1);
  assign sp_p1     = sp + PW'(1);
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign count     = cnt;
  assign top_addr  = empty ? '0 : mem[sp_m1];

  // Next pointer/count, memory write and error events; restore masks push/pop.
  always_comb begin
    sp_nxt  = sp;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_idx  = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (restore) begin
      sp_nxt  = saved_sp;
      cnt_nxt = saved_cnt;
    end else if (push && pop && !empty) begin
      // replace top in place; never an error, even when full
      wr_en  = 1'b1;
      wr_idx = sp_m1;
    end else if (push) begin
      // push alone, or push+pop on an empty stack
      if (!full) begin
        wr_en   = 1'b1;
        sp_nxt  = sp_p1;
        cnt_nxt = cnt + CW'(1);
      end else begin
        ovf_set = 1'b1;
        if (OVF_WRAP != 0) begin
          // overwrite the oldest slot; count stays at DEPTH
          wr_en  = 1'b1;
          sp_nxt = sp_p1;
        end
      end
    end else if (pop) begin
      if (!empty) begin
        sp_nxt  = sp_m1;
        cnt_nxt = cnt - CW'(1);
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  // State update; checkpoint always captures pre-update pointer/count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sp        <= '0;
      cnt       <= '0;
      saved_sp  <= '0;
      saved_cnt <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) mem[wr_idx] <= push_addr;
      sp  <= sp_nxt;
      cnt <= cnt_nxt;
      if (ckpt) begin
        saved_sp  <= sp;
        saved_cnt <= cnt;
      end
      // a new error in the same cycle beats clr_err
      overflow  <= ovf_set | (overflow  & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end
endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench: two stacks (drop and wrap policies) share stimulus; each is checked
// against a behavioural array model plus directed constant expectations.
module tb_ret_addr_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 12;
  localparam int CW    = 4;
  localparam int VW    = AW + CW + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, push = 1'b0, pop = 1'b0, ckpt = 1'b0, restore = 1'b0, clr_err = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic [AW-1:0] top0, top1;
  logic [CW-1:0] cnt0, cnt1;
  logic          e0, e1, f0, f1, o0, o1, u0, u1;

  ret_addr_stack #(.DEPTH(DEPTH), .AW(AW), .OVF_WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .ckpt(ckpt), .restore(restore), .clr_err(clr_err), .top_addr(top0),
    .count(cnt0), .empty(e0), .full(f0), .overflow(o0), .underflow(u0));

  ret_addr_stack #(.DEPTH(DEPTH), .AW(AW), .OVF_WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .ckpt(ckpt), .restore(restore), .clr_err(clr_err), .top_addr(top1),
    .count(cnt1), .empty(e1), .full(f1), .overflow(o1), .underflow(u1));

  // reference model, index 0 = drop policy, 1 = wrap policy
  logic [AW-1:0] m_mem [2][DEPTH];
  int            m_sp [2], m_cnt [2], m_ssp [2], m_scnt [2];
  bit            m_ovf [2], m_unf [2];

  int n_chk  = 0;
  int n_fail = 0;

  // apply the current inputs to the model (call before the edge)
  task automatic model_step();
    for (int w = 0; w < 2; w++) begin
      int o_sp, o_cnt;
      bit nov, nun;
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) m_mem[w][i] = '0;
        m_sp[w] = 0; m_cnt[w] = 0; m_ssp[w] = 0; m_scnt[w] = 0;
        m_ovf[w] = 0; m_unf[w] = 0;
      end else begin
        o_sp = m_sp[w]; o_cnt = m_cnt[w];
        nov = 0; nun = 0;
        if (restore) begin
          m_sp[w] = m_ssp[w]; m_cnt[w] = m_scnt[w];
        end else if (push && pop && m_cnt[w] > 0) begin
          m_mem[w][(m_sp[w] + DEPTH - 1) % DEPTH] = push_addr;
        end else if (push) begin
          if (m_cnt[w] < DEPTH) begin
            m_mem[w][m_sp[w]] = push_addr;
            m_sp[w] = (m_sp[w] + 1) % DEPTH;
            m_cnt[w]++;
          end else begin
            nov = 1;
            if (w == 1) begin
              m_mem[w][m_sp[w]] = push_addr;
              m_sp[w] = (m_sp[w] + 1) % DEPTH;
            end
          end
        end else if (pop) begin
          if (m_cnt[w] > 0) begin
            m_sp[w] = (m_sp[w] + DEPTH - 1) % DEPTH;
            m_cnt[w]--;
          end else nun = 1;
        end
        if (ckpt) begin m_ssp[w] = o_sp; m_scnt[w] = o_cnt; end
        m_ovf[w] = nov | (m_ovf[w] & !clr_err);
        m_unf[w] = nun | (m_unf[w] & !clr_err);
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec(int w);
    logic [AW-1:0] t;
    logic [CW-1:0] c;
    t = (m_cnt[w] == 0) ? '0 : m_mem[w][(m_sp[w] + DEPTH - 1) % DEPTH];
    c = m_cnt[w][CW-1:0];
    return {t, c, m_cnt[w] == 0, m_cnt[w] == DEPTH, m_ovf[w], m_unf[w]};
  endfunction

  function automatic logic [VW-1:0] dut_vec(int w);
    if (w == 0) return {top0, cnt0, e0, f0, o0, u0};
    return {top1, cnt1, e1, f1, o1, u1};
  endfunction

  // one clock with the given command; outputs are settled on return
  task automatic cyc(input bit p, input bit po, input logic [AW-1:0] a,
                     input bit ck, input bit rs, input bit ce, input bit r);
    push = p; pop = po; push_addr = a; ckpt = ck; restore = rs; clr_err = ce; rst = r;
    model_step();
    @(posedge clk);
    #1;
    push = 0; pop = 0; ckpt = 0; restore = 0; clr_err = 0; rst = 0;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int w = 0; w < 2; w++) begin
      n_chk++;
      if (dut_vec(w) !== VW'(20'h00008)) begin
        n_fail++; $display("FAIL reset[%0d]: got %h want %h", w, dut_vec(w), 20'h00008);
      end
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] want [3];
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) cyc(1, 0, AW'(12'h100 + i), 0, 0, 0, 0);
    n_chk++;
    if (top0 !== 12'h103 || cnt0 !== 4'd3) begin
      n_fail++; $display("FAIL basic_push: got top=%h cnt=%0d want top=103 cnt=3", top0, cnt0);
    end
    want[0] = 12'h102; want[1] = 12'h101; want[2] = 12'h000;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      n_chk++;
      if (top0 !== want[i]) begin
        n_fail++; $display("FAIL basic_pop%0d: got top=%h want %h", i, top0, want[i]);
      end
    end
    n_chk++;
    if (e0 !== 1'b1 || u0 !== 1'b0) begin
      n_fail++; $display("FAIL basic_empty: got empty=%b underflow=%b want 1 0", e0, u0);
    end
  endtask

  task automatic test_overflow();
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 0, AW'(12'h200 + i), 0, 0, 0, 0);
    n_chk++;
    if ({top0, cnt0, f0, o0} !== {12'h207, 4'd8, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ovf_drop: got top=%h cnt=%0d full=%b ovf=%b want 207 8 1 1", top0, cnt0, f0, o0);
    end
    n_chk++;
    if ({top1, cnt1, o1} !== {12'h208, 4'd8, 1'b1}) begin
      n_fail++; $display("FAIL ovf_wrap: got top=%h cnt=%0d ovf=%b want 208 8 1", top1, cnt1, o1);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_chk++;
    if (o0 !== 1'b0 || o1 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr: got ovf0=%b ovf1=%b want 0 0", o0, o1);
    end
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (top1 !== AW'(12'h208 - k)) begin
        n_fail++; $display("FAIL wrap_pop%0d: got top=%h want %h", k, top1, 12'h208 - k);
      end
      cyc(0, 1, 0, 0, 0, 0, 0);
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (dut_vec(w) !== exp_vec(w)) begin
          n_fail++; $display("FAIL ovf_model[%0d]: got %h want %h", w, dut_vec(w), exp_vec(w));
        end
      end
    end
    n_chk++;
    if (e1 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_empty: got empty=%b want 1", e1);
    end
  endtask

  task automatic test_underflow();
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_chk++;
    if (u0 !== 1'b1 || cnt0 !== 4'd0) begin
      n_fail++; $display("FAIL unf_pop: got unf=%b cnt=%0d want 1 0", u0, cnt0);
    end
    cyc(1, 1, 12'h0AA, 0, 0, 0, 0);
    n_chk++;
    if ({cnt0, top0, u0} !== {4'd1, 12'h0AA, 1'b1}) begin
      n_fail++; $display("FAIL unf_pushpop: got cnt=%0d top=%h unf=%b want 1 0aa 1", cnt0, top0, u0);
    end
  endtask

  task automatic test_ckpt();
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 12'h010, 0, 0, 0, 0);
    cyc(1, 0, 12'h020, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 12'h030, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    n_chk++;
    if (cnt0 !== 4'd2 || top0 !== 12'h020) begin
      n_fail++; $display("FAIL ckpt_restore: got cnt=%0d top=%h want 2 020", cnt0, top0);
    end
    cyc(1, 1, 12'h040, 0, 0, 0, 0);
    n_chk++;
    if (top0 !== 12'h040 || cnt0 !== 4'd2) begin
      n_fail++; $display("FAIL ckpt_replace: got top=%h cnt=%0d want 040 2", top0, cnt0);
    end
  endtask

  task automatic test_rst_priority();
    cyc(1, 0, 12'h055, 1, 0, 0, 0);
    cyc(1, 0, 12'h111, 0, 0, 0, 1);
    n_chk++;
    if (dut_vec(0) !== VW'(20'h00008)) begin
      n_fail++; $display("FAIL rst_push: got %h want %h", dut_vec(0), 20'h00008);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    n_chk++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
      n_fail++; $display("FAIL rst_restore: got cnt0=%0d cnt1=%0d want 0 0", cnt0, cnt1);
    end
  endtask

  task automatic test_random();
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      int r;
      bit p, po;
      r  = $urandom_range(0, 99);
      p  = (r < 55);
      po = (r >= 40 && r < 85);
      cyc(p, po, AW'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (dut_vec(w) !== exp_vec(w)) begin
          n_fail++; $display("FAIL rand[%0d] cyc %0d: got %h want %h", w, n, dut_vec(w), exp_vec(w));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_ckpt();
    test_rst_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
